// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache responder with beat-wise line refill
package mmm_pkg;
  localparam int XLEN = 32;
  localparam int ICACHE_LINE_W = 128;
  localparam int ICACHE_OFFSET = $clog2(ICACHE_LINE_W / 8);
  typedef struct packed {
    logic [ICACHE_LINE_W-1:0] line;
    logic [XLEN-1:0]          pc;
  } icache_out_t;
endpackage

module icache_ctrl
  import mmm_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int N_SETS = 16,
  parameter int MEM_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              invalidate_i,
  input  logic              read_req_i,
  input  logic [XLEN-1:0]   addr_i,
  output logic              read_done_o,
  output icache_out_t       cache_out_o,
  output logic              busy_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic              mem_resp_valid_i,
  input  logic [MEM_W-1:0]  mem_resp_data_i
);
  localparam int BEATS = LINE_W / MEM_W;
  localparam int OW = $clog2(LINE_W / 8);
  localparam int IW = $clog2(N_SETS);
  localparam int TW = XLEN - OW - IW;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, REFILL, DONE} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic discard_q, discard_d, inv_pend_q, inv_pend_d;
  logic [N_SETS-1:0] valid_q, valid_d;
  icache_out_t out_q, out_d;
  logic [TW-1:0] tag_mem [N_SETS];
  logic [LINE_W-1:0] data_mem [N_SETS];
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, last, inv_now;
  assign idx = addr_q[OW +: IW];
  assign tag = addr_q[XLEN-1 -: TW];
  assign hit = valid_q[idx] && tag_mem[idx] == tag;
  assign last = state_q == REFILL && mem_resp_valid_i && cnt_q == CW'(BEATS - 1);
  assign inv_now = state_q == IDLE && (invalidate_i || inv_pend_q);
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      buf_q      <= '0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      inv_pend_q <= 1'b0;
      valid_q    <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      inv_pend_q <= inv_pend_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
    end
  end
  // Array contents need no reset; the valid bits gate every hit.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && last) begin
      data_mem[idx] <= buf_d;
      tag_mem[idx]  <= tag;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = read_req_i && !flush_i ? LOOKUP : IDLE;
      LOOKUP:  state_d = flush_i ? IDLE : hit ? DONE : MEM_REQ;
      MEM_REQ: state_d = mem_req_ready_i ? REFILL : flush_i ? IDLE : MEM_REQ;
      REFILL:  state_d = !last ? REFILL : (discard_q || flush_i) ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    addr_d = state_q == IDLE && read_req_i && !flush_i ? addr_i & ~XLEN'(LINE_W / 8 - 1) : addr_q;
    buf_d = buf_q;
    if (state_q == REFILL && mem_resp_valid_i) buf_d[cnt_q * MEM_W +: MEM_W] = mem_resp_data_i;
    cnt_d = state_q == MEM_REQ ? '0 : state_q == REFILL && mem_resp_valid_i ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    discard_d = state_q == MEM_REQ ? flush_i : state_q == REFILL ? discard_q || flush_i : 1'b0;
    inv_pend_d = state_q != IDLE && (inv_pend_q || invalidate_i);
    valid_d = valid_q;
    if (inv_now) valid_d = '0;
    else if (last) valid_d[idx] = 1'b1;
    out_d = out_q;
    if (state_d == DONE) begin
      out_d.line = state_q == LOOKUP ? data_mem[idx] : buf_d;
      out_d.pc   = addr_q;
    end
  end
  always_comb begin
    busy_o          = state_q != IDLE;
    mem_req_valid_o = state_q == MEM_REQ;
    read_done_o     = state_q == DONE && !flush_i;
    mem_addr_o      = addr_q;
    cache_out_o     = out_q;
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed scoreboard bench for icache_ctrl hit, miss, flush and invalidate paths
module tb_icache_ctrl;
  import mmm_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, inv = 0, req = 0, mrdy = 0, mrv = 0;
  logic [31:0] addr = 0, mdata = 0;
  logic done, busy, mreq;
  logic [31:0] maddr;
  icache_out_t cout;
  int n_cmp = 0, n_err = 0, done_cnt = 0;
  icache_out_t sb[$];
  always #5 clk = ~clk;
  icache_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .invalidate_i(inv),
    .read_req_i(req), .addr_i(addr), .read_done_o(done), .cache_out_o(cout),
    .busy_o(busy), .mem_req_valid_o(mreq), .mem_req_ready_i(mrdy),
    .mem_addr_o(maddr), .mem_resp_valid_i(mrv), .mem_resp_data_i(mdata)
  );
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] mk_line(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction
  icache_out_t e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      chk("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("line", cout.line, e.line);
        chk("pc", cout.pc, e.pc);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic request(input logic [31:0] a);
    req = 1;
    addr = a;
    cyc();
    req = 0;
  endtask
  task automatic serve(input logic [31:0] a, input logic [31:0] base, input int wt, input int fl_at, input int inv_at);
    int k = 0;
    while (!mreq && k < 10) begin
      cyc();
      k++;
    end
    chk("mem_req_seen", mreq, 1);
    if (!mreq) return;
    for (int i = 0; i < wt; i++) begin
      chk("bp_valid", mreq, 1);
      chk("bp_addr", maddr, a);
      cyc();
    end
    chk("mem_addr", maddr, a);
    mrdy = 1;
    cyc();
    mrdy = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == fl_at) begin flush = 1; cyc(); flush = 0; end
      if (i == inv_at) begin inv = 1; cyc(); inv = 0; end
      mrv = 1;
      mdata = base + i;
      cyc();
      mrv = 0;
    end
  endtask
  task automatic miss(input logic [31:0] a, input logic [31:0] pc, input logic [31:0] base,
                      input int wt, input int fl_at, input int inv_at, input logic ir);
    int d0 = done_cnt;
    if (fl_at < 0) sb.push_back('{line: mk_line(base), pc: pc});
    inv = ir;
    request(a);
    inv = 0;
    serve(pc, base, wt, fl_at, inv_at);
    if (fl_at < 0) begin
      int k = 0;
      while (done_cnt == d0 && k < 10) begin
        cyc();
        k++;
      end
      chk("done_seen", done_cnt != d0, 1);
    end else begin
      repeat (4) cyc();
      chk("no_done", done_cnt, d0);
    end
    chk("idle_after", busy, 0);
  endtask
  task automatic hit(input logic [31:0] a, input logic [31:0] pc, input logic [127:0] line);
    sb.push_back('{line: line, pc: pc});
    request(a);
    chk("hit_early_done", done, 0);
    chk("hit_no_mreq", mreq, 0);
    cyc();
    chk("hit_done", done, 1);
    chk("hit_no_mreq2", mreq, 0);
    cyc();
    chk("hit_idle", busy, 0);
  endtask
  initial begin
    int d0;
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    repeat (3) cyc();
    chk("rst_done", done, 0);
    chk("rst_out", cout, 0);
    chk("rst_mreq", mreq, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    cyc();
    miss(32'h1004, 32'h1000, 32'hA, 0, -1, -1, 0);
    hit(32'h100C, 32'h1000, mk_line(32'hA));
    miss(32'h1100, 32'h1100, 32'h11, 0, -1, -1, 0);
    miss(32'h1000, 32'h1000, 32'hA, 0, -1, -1, 0);
    miss(32'h2040, 32'h2040, 32'h21, 0, 2, -1, 0);
    hit(32'h1000, 32'h1000, mk_line(32'hA));
    hit(32'h2040, 32'h2040, mk_line(32'h21));
    d0 = done_cnt;
    request(32'h3080);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", mreq, 1);
      chk("t5_addr", maddr, 32'h3080);
      cyc();
    end
    flush = 1;
    cyc();
    flush = 0;
    chk("t5_flush_mreq", mreq, 0);
    chk("t5_flush_busy", busy, 0);
    repeat (3) cyc();
    chk("t5_no_req", mreq, 0);
    chk("t5_no_done", done_cnt, d0);
    miss(32'h3080, 32'h3080, 32'h31, 3, -1, -1, 0);
    miss(32'h4000, 32'h4000, 32'h41, 0, -1, 1, 0);
    miss(32'h4000, 32'h4000, 32'h51, 0, -1, -1, 0);
    hit(32'h4000, 32'h4000, mk_line(32'h51));
    miss(32'h4000, 32'h4000, 32'h61, 0, -1, -1, 1);
    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
